// File: rtl/ofm_writeback_if.sv
// Bus bundle for ofm_writeback: the 8-bit OFM result stream coming in and the
// word-write port going out to output feature-map memory.
interface ofm_writeback_if #(
  parameter int OFM_WIDTH  = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  ofm_valid;
  logic [OFM_WIDTH-1:0]  ofm_data;
  logic                  ofm_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_byte_en;
  logic                  mem_ready;

  // master: the write-back block; slave: the stream source and the memory
  modport master (
    input  ofm_valid, ofm_data, mem_ready,
    output ofm_ready, mem_wr_en, mem_addr, mem_wdata, mem_byte_en
  );
  modport slave (
    output ofm_valid, ofm_data, mem_ready,
    input  ofm_ready, mem_wr_en, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/ofm_writeback.sv
// OFM write-back: packs the 8-bit result stream little-endian into 32-bit words,
// one row per word-aligned run, and writes them from a programmed base address.
module ofm_writeback #(
  parameter int OFM_WIDTH  = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  ofm_cols,
  input  logic [DIM_WIDTH-1:0]  ofm_rows,
  ofm_writeback_if.master      bus,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DIM_WIDTH-1:0]  cols_r;
  logic [DIM_WIDTH-1:0]  rows_r;
  logic [DIM_WIDTH-1:0]  col_r;
  logic [DIM_WIDTH-1:0]  row_r;
  logic [1:0]            lane_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic [3:0]            be_r;
  logic                  last_r;
  logic                  ofm_ready_r;
  logic                  wr_en_r;
  logic                  busy_r;
  logic                  done_r;

  logic accept_s;
  logic row_end_s;
  logic layer_end_s;

  assign accept_s    = bus.ofm_valid && ofm_ready_r;
  assign row_end_s   = (col_r == cols_r - DIM_WIDTH'(1));
  assign layer_end_s = row_end_s && (row_r == rows_r - DIM_WIDTH'(1));

  assign bus.ofm_ready   = ofm_ready_r;
  assign bus.mem_wr_en   = wr_en_r;
  assign bus.mem_addr    = addr_r;
  assign bus.mem_wdata   = data_r;
  assign bus.mem_byte_en = be_r;
  assign busy            = busy_r;
  assign done            = done_r;

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      cols_r      <= {DIM_WIDTH{1'b0}};
      rows_r      <= {DIM_WIDTH{1'b0}};
      col_r       <= {DIM_WIDTH{1'b0}};
      row_r       <= {DIM_WIDTH{1'b0}};
      lane_r      <= 2'd0;
      data_r      <= {WORD_WIDTH{1'b0}};
      be_r        <= 4'b0000;
      last_r      <= 1'b0;
      ofm_ready_r <= 1'b0;
      wr_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if ((ofm_cols != {DIM_WIDTH{1'b0}}) && (ofm_rows != {DIM_WIDTH{1'b0}})) begin
              addr_r      <= base_addr;
              cols_r      <= ofm_cols;
              rows_r      <= ofm_rows;
              col_r       <= {DIM_WIDTH{1'b0}};
              row_r       <= {DIM_WIDTH{1'b0}};
              lane_r      <= 2'd0;
              data_r      <= {WORD_WIDTH{1'b0}};
              be_r        <= 4'b0000;
              last_r      <= 1'b0;
              ofm_ready_r <= 1'b1;
              state_r     <= PACK;
            end else begin
              state_r <= DONE;
            end
          end
        end
        PACK: begin
          if (accept_s) begin
            for (int i = 0; i < 4; i++) begin
              if (lane_r == 2'(i)) begin
                data_r[i*OFM_WIDTH +: OFM_WIDTH] <= bus.ofm_data;
                be_r[i]                          <= 1'b1;
              end
            end
            if (row_end_s) begin
              col_r <= {DIM_WIDTH{1'b0}};
              row_r <= row_r + DIM_WIDTH'(1);
            end else begin
              col_r <= col_r + DIM_WIDTH'(1);
            end
            if (layer_end_s) begin
              last_r <= 1'b1;
            end
            // A row end flushes a partial word so the next row starts aligned
            if ((lane_r == 2'd3) || row_end_s) begin
              ofm_ready_r <= 1'b0;
              wr_en_r     <= 1'b1;
              state_r     <= WRITE;
            end else begin
              lane_r <= lane_r + 2'd1;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            wr_en_r <= 1'b0;
            addr_r  <= addr_r + ADDR_WIDTH'(1);
            lane_r  <= 2'd0;
            be_r    <= 4'b0000;
            data_r  <= {WORD_WIDTH{1'b0}};
            if (last_r) begin
              state_r <= DONE;
            end else begin
              ofm_ready_r <= 1'b1;
              state_r     <= PACK;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: expected writes are queued by a packing
// model when a layer is launched and compared against the writes the DUT issues.
module tb_ofm_writeback;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [7:0]  ofm_cols;
  logic [7:0]  ofm_rows;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int cyc;
  int first_acc;
  int done_cyc;

  wr_t        exp_q[$];
  wr_t        got_q[$];
  logic [7:0] bytes_q[$];

  ofm_writeback_if #(.OFM_WIDTH(8), .WORD_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  ofm_writeback #(.OFM_WIDTH(8), .WORD_WIDTH(32), .ADDR_WIDTH(12), .DIM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .ofm_cols(ofm_cols), .ofm_rows(ofm_rows), .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every completed memory write
  always @(negedge clk) begin
    if (rst_n && bus.mem_wr_en && bus.mem_ready)
      got_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, be: bus.mem_byte_en});
  end

  // Reference packing: word-aligned rows, little-endian lanes, zero-filled tail
  task automatic push_layer(input logic [11:0] base, input int cols, input int rows);
    logic [11:0] a;
    logic [31:0] w;
    logic [3:0]  be;
    int idx;
    a = base;
    idx = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c += 4) begin
        w = 32'h0;
        be = 4'b0000;
        for (int l = 0; l < 4; l++) begin
          if (c + l < cols) begin
            w = w | (32'(bytes_q[idx]) << (8 * l));
            be = be | (4'b0001 << l);
            idx++;
          end
        end
        exp_q.push_back('{addr: a, data: w, be: be});
        a = a + 12'd1;
      end
    end
  endtask

  task automatic start_layer(input logic [11:0] base, input logic [7:0] cols, input logic [7:0] rows);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; ofm_cols = cols; ofm_rows = rows;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream();
    int n;
    for (int i = 0; i < bytes_q.size(); i++) begin
      bus.ofm_valid = 1'b1;
      bus.ofm_data = bytes_q[i];
      n = 0;
      @(negedge clk);
      while (!bus.ofm_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (!bus.ofm_ready) begin
        checks++; failures++;
        $display("FAIL stream_timeout: ofm_ready=%b after %0d cycles, expected 1", bus.ofm_ready, n);
        bus.ofm_valid = 1'b0;
        return;
      end
      if (i == 0) first_acc = cyc;
      @(posedge clk); #1;
    end
    bus.ofm_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = 12'h0; ofm_cols = 8'd0; ofm_rows = 8'd0;
    bus.ofm_valid = 1'b0; bus.ofm_data = 8'h00; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, bus.ofm_ready, busy, done} !== 51'h0) begin
      failures++;
      $display("FAIL reset_outputs: wr_en=%b addr=%h wdata=%h be=%b ready=%b busy=%b done=%b, expected all 0",
               bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, bus.ofm_ready, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ofm_ready, busy, bus.mem_wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b busy=%b wr_en=%b, expected 000", bus.ofm_ready, busy, bus.mem_wr_en);
    end
  endtask

  task automatic test_single_word();
    wr_t g, e;
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_layer(12'h010, 4, 1);
    start_layer(12'h010, 8'd4, 8'd1);
    stream();
    @(negedge clk);
    checks++;
    if (bus.mem_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL write_latency: mem_wr_en=%b the cycle after the last accept, expected 1", bus.mem_wr_en);
    end
    wait_done();
    checks++;
    if (done_cyc - first_acc !== 6) begin
      failures++;
      $display("FAIL accept_to_done: %0d cycles, expected 6", done_cyc - first_acc);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_with_done: busy=%b, expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_width: done=%b in the second cycle, expected 0", done);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL single_count: writes=%0d expected=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL single_write: got addr=%h data=%h be=%b expected addr=%h data=%h be=%b", g.addr, g.data, g.be, e.addr, e.data, e.be);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_two_rows();
    wr_t g, e;
    bytes_q.delete();
    for (int i = 0; i < 12; i++) bytes_q.push_back(8'(i));
    push_layer(12'h000, 6, 2);
    start_layer(12'h000, 8'd6, 8'd2);
    // A second launch while busy must not disturb the running layer
    start = 1'b1; base_addr = 12'h100; ofm_cols = 8'd1; ofm_rows = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    stream();
    wait_done();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL two_rows_count: writes=%0d expected=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL two_rows_write: got addr=%h data=%h be=%b expected addr=%h data=%h be=%b", g.addr, g.data, g.be, e.addr, e.data, e.be);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    wr_t g, e, snap;
    int n;
    bytes_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    push_layer(12'hFFF, 4, 2);
    bus.mem_ready = 1'b0;
    start_layer(12'hFFF, 8'd4, 8'd2);
    fork
      stream();
      begin
        n = 0;
        @(negedge clk);
        while (!bus.mem_wr_en && n < 200) begin
          n++;
          @(negedge clk);
        end
        snap = '{addr: bus.mem_addr, data: bus.mem_wdata, be: bus.mem_byte_en};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (bus.mem_wr_en !== 1'b1 || bus.ofm_ready !== 1'b0 ||
              {bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== snap) begin
            failures++;
            $display("FAIL stall_hold: wr_en=%b ready=%b addr=%h data=%h be=%b, expected 1 0 %h %h %b",
                     bus.mem_wr_en, bus.ofm_ready, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en,
                     snap.addr, snap.data, snap.be);
          end
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
      end
    join
    wait_done();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL stall_count: writes=%0d expected=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL stall_write: got addr=%h data=%h be=%b expected addr=%h data=%h be=%b", g.addr, g.data, g.be, e.addr, e.data, e.be);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_negative();
    wr_t g;
    bytes_q = '{8'h80, 8'hFF, 8'h7F, 8'h01};
    start_layer(12'h200, 8'd4, 8'd1);
    stream();
    wait_done();
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL negative_count: writes=%0d expected=1", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g.data !== 32'h017FFF80 || g.be !== 4'b1111 || g.addr !== 12'h200) begin
        failures++;
        $display("FAIL negative_word: addr=%h data=%h be=%b expected addr=200 data=017fff80 be=1111", g.addr, g.data, g.be);
      end
    end
    got_q.delete();
  endtask

  task automatic test_zero_cols();
    start_layer(12'h050, 8'd0, 8'd5);
    start = 1'b1; base_addr = 12'h060; ofm_cols = 8'd4; ofm_rows = 8'd1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL zero_first_cycle: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL zero_done: busy=%b done=%b, expected busy=0 done=1", busy, done);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, bus.ofm_ready} !== 3'b000) begin
      failures++;
      $display("FAIL zero_restart_ignored: busy=%b done=%b ready=%b, expected 000", busy, done, bus.ofm_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() !== 0) begin
      failures++;
      $display("FAIL zero_writes: writes=%0d expected=0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    wr_t g, e;
    bytes_q = '{8'h55, 8'h66};
    start_layer(12'h020, 8'd4, 8'd1);
    stream();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, bus.ofm_ready, busy, done} !== 51'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: wr_en=%b addr=%h wdata=%h be=%b ready=%b busy=%b done=%b, expected all 0",
               bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, bus.ofm_ready, busy, done);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || got_q.size() !== 0) begin
        failures++;
        $display("FAIL mid_reset_quiet: done=%b writes=%0d, expected done=0 writes=0", done, got_q.size());
      end
    end
    got_q.delete();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_layer(12'h030, 4, 1);
    start_layer(12'h030, 8'd4, 8'd1);
    stream();
    wait_done();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL after_reset_count: writes=%0d expected=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL after_reset_write: got addr=%h data=%h be=%b expected addr=%h data=%h be=%b", g.addr, g.data, g.be, e.addr, e.data, e.be);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    first_acc = 0;
    done_cyc = 0;
    test_reset();
    test_single_word();
    test_two_rows();
    test_backpressure();
    test_negative();
    test_zero_cols();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
